// File: rtl/cpu_lsu_pkg.sv
// Shared types for the load/store unit: opcodes, FSM states, access sizes,
// the decoded-opcode record and small decode helpers.
package cpu_lsu_pkg;

    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_LANES  = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_LB  = 4'd5,
        OP_LBU = 4'd6,
        OP_LH  = 4'd7,
        OP_LHU = 4'd8,
        OP_LW  = 4'd9,
        OP_SB  = 4'd10,
        OP_SH  = 4'd11,
        OP_SW  = 4'd12
    } opcode_t;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Decoded view of an opcode as seen by the LSU.
    typedef struct packed {
        logic      is_load;
        logic      is_store;
        logic      is_unsigned;
        lsu_size_t size;
    } lsu_op_info_t;

    // Map an opcode to load/store kind, size and extension; non-memory ops decode to all-zero.
    function automatic lsu_op_info_t decode_op(input opcode_t op);
        lsu_op_info_t info;
        info = '0;
        case (op)
            OP_LB:  begin info.is_load = 1'b1; info.size = SZ_BYTE; end
            OP_LBU: begin info.is_load = 1'b1; info.size = SZ_BYTE; info.is_unsigned = 1'b1; end
            OP_LH:  begin info.is_load = 1'b1; info.size = SZ_HALF; end
            OP_LHU: begin info.is_load = 1'b1; info.size = SZ_HALF; info.is_unsigned = 1'b1; end
            OP_LW:  begin info.is_load = 1'b1; info.size = SZ_WORD; end
            OP_SB:  begin info.is_store = 1'b1; info.size = SZ_BYTE; end
            OP_SH:  begin info.is_store = 1'b1; info.size = SZ_HALF; end
            OP_SW:  begin info.is_store = 1'b1; info.size = SZ_WORD; end
            default: info = '0;
        endcase
        return info;
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = |offset;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/cpu_lsu_lane.sv
// Byte-lane steering for the LSU (purely combinational).
//   i_size, i_unsigned, i_offset : access shape
//   i_store_data                 : register value to store (datum in low bits)
//   i_readdata                   : raw bus read word
//   o_byteenable_c               : active lanes for the access
//   o_writedata_c                : store datum replicated onto its lanes
//   o_load_data_c                : selected lane(s), sign/zero-extended
// Half accesses ignore offset[0]; word accesses ignore the offset entirely.
module cpu_lsu_lane
    import cpu_lsu_pkg::*;
(
    input  lsu_size_t                i_size,
    input  logic                     i_unsigned,
    input  logic [1:0]               i_offset,
    input  logic [LSU_DATA_W-1:0]    i_store_data,
    input  logic [LSU_DATA_W-1:0]    i_readdata,
    output logic [LSU_LANES-1:0]     o_byteenable_c,
    output logic [LSU_DATA_W-1:0]    o_writedata_c,
    output logic [LSU_DATA_W-1:0]    o_load_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection for loads.
    assign w_byte = i_readdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_readdata[31:16] : i_readdata[15:0];

    always_comb begin
        o_byteenable_c = '0;
        o_writedata_c  = '0;
        o_load_data_c  = '0;
        case (i_size)
            SZ_BYTE: begin
                o_byteenable_c = 4'b0001 << i_offset;
                o_writedata_c  = {4{i_store_data[7:0]}};
                o_load_data_c  = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_byteenable_c = i_offset[1] ? 4'b1100 : 4'b0011;
                o_writedata_c  = {2{i_store_data[15:0]}};
                o_load_data_c  = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_byteenable_c = 4'b1111;
                o_writedata_c  = i_store_data;
                o_load_data_c  = i_readdata;
            end
            default: begin
                o_byteenable_c = '0;
                o_writedata_c  = '0;
                o_load_data_c  = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: runs one Avalon-style read or write per request and
// returns an aligned, extended load value for write-back.
//   clk, reset_i            : clock, async active-high reset
//   start_i, opcode_i       : request strobe (sampled in IDLE) and operation
//   address_i, store_data_i : effective address, register value to store
//   busy_o, done_o          : not-idle flag, one-cycle completion pulse
//   load_data_o             : extended load result, held until the next load
//   avm_*                   : Avalon-MM master (address, read, write,
//                             writedata, byteenable, waitrequest, readdata)
//   addr_error_o            : misaligned access flag (only with CPU_LSU_ADDR_ERROR_EN)
// Optional build macro: CPU_LSU_ADDR_ERROR_EN -- misaligned half/word accesses
// complete immediately with addr_error_o instead of running a bus cycle.
module cpu_lsu
    import cpu_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
)
(
    input  logic                clk,
    input  logic                reset_i,
    input  logic                start_i,
    input  opcode_t             opcode_i,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic [DATA_W-1:0]   store_data_i,
    output logic                busy_o,
    output logic                done_o,
`ifdef CPU_LSU_ADDR_ERROR_EN
    output logic                addr_error_o,
`endif
    output logic [DATA_W-1:0]   load_data_o,
    output logic [ADDR_W-1:0]   avm_address_o,
    output logic                avm_read_o,
    output logic                avm_write_o,
    output logic [DATA_W-1:0]   avm_writedata_o,
    output logic [3:0]          avm_byteenable_o,
    input  logic                avm_waitrequest_i,
    input  logic [DATA_W-1:0]   avm_readdata_i
);

    lsu_state_t          r_state,     w_state_next;
    logic                r_read,      w_read_next;
    logic                r_write,     w_write_next;
    logic                r_done,      w_done_next;
    logic                r_busy,      w_busy_next;
    logic [ADDR_W-1:0]   r_addr,      w_addr_next;
    logic [3:0]          r_be,        w_be_next;
    logic [DATA_W-1:0]   r_wdata,     w_wdata_next;
    logic [DATA_W-1:0]   r_load_data, w_load_next;
    lsu_size_t           r_size,      w_size_next;
    logic                r_unsigned,  w_unsigned_next;
    logic                r_is_load,   w_is_load_next;
    logic [1:0]          r_off,       w_off_next;
`ifdef CPU_LSU_ADDR_ERROR_EN
    logic                r_addr_err,  w_addr_err_next;
`endif

    lsu_op_info_t        w_in_info;
    logic                w_misaligned;
    lsu_size_t           w_lane_size;
    logic                w_lane_unsigned;
    logic [1:0]          w_lane_off;
    logic [3:0]          w_lane_be;
    logic [DATA_W-1:0]   w_lane_wdata;
    logic [DATA_W-1:0]   w_lane_load;

    assign w_in_info = decode_op(opcode_i);

`ifdef CPU_LSU_ADDR_ERROR_EN
    assign w_misaligned = is_misaligned(w_in_info.size, address_i[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // In IDLE the lane logic shapes the incoming request; afterwards it
    // extracts read data using the latched access shape.
    assign w_lane_size     = (r_state == LSU_IDLE) ? w_in_info.size        : r_size;
    assign w_lane_unsigned = (r_state == LSU_IDLE) ? w_in_info.is_unsigned : r_unsigned;
    assign w_lane_off      = (r_state == LSU_IDLE) ? address_i[1:0]        : r_off;

    cpu_lsu_lane u_lane (
        .i_size         (w_lane_size),
        .i_unsigned     (w_lane_unsigned),
        .i_offset       (w_lane_off),
        .i_store_data   (store_data_i),
        .i_readdata     (avm_readdata_i),
        .o_byteenable_c (w_lane_be),
        .o_writedata_c  (w_lane_wdata),
        .o_load_data_c  (w_lane_load)
    );

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state_next    = r_state;
        w_read_next     = r_read;
        w_write_next    = r_write;
        w_done_next     = 1'b0;
        w_busy_next     = r_busy;
        w_addr_next     = r_addr;
        w_be_next       = r_be;
        w_wdata_next    = r_wdata;
        w_load_next     = r_load_data;
        w_size_next     = r_size;
        w_unsigned_next = r_unsigned;
        w_is_load_next  = r_is_load;
        w_off_next      = r_off;
`ifdef CPU_LSU_ADDR_ERROR_EN
        w_addr_err_next = 1'b0;
`endif
        case (r_state)
            LSU_IDLE: begin
                if (start_i && (w_in_info.is_load || w_in_info.is_store)) begin
                    w_size_next     = w_in_info.size;
                    w_unsigned_next = w_in_info.is_unsigned;
                    w_is_load_next  = w_in_info.is_load;
                    w_off_next      = address_i[1:0];
                    w_busy_next     = 1'b1;
                    if (w_misaligned) begin
                        // Faulting access: complete without touching the bus.
                        w_state_next = LSU_DONE;
                        w_done_next  = 1'b1;
`ifdef CPU_LSU_ADDR_ERROR_EN
                        w_addr_err_next = 1'b1;
`endif
                    end else begin
                        w_state_next = LSU_ACCESS;
                        w_addr_next  = {address_i[ADDR_W-1:2], 2'b00};
                        w_be_next    = w_lane_be;
                        w_wdata_next = w_lane_wdata;
                        w_read_next  = w_in_info.is_load;
                        w_write_next = w_in_info.is_store;
                    end
                end
            end
            LSU_ACCESS: begin
                if (!avm_waitrequest_i) begin
                    w_read_next  = 1'b0;
                    w_write_next = 1'b0;
                    w_state_next = LSU_DONE;
                    w_done_next  = 1'b1;
                    if (r_is_load) begin
                        w_load_next = w_lane_load;
                    end
                end
            end
            LSU_DONE: begin
                w_state_next = LSU_IDLE;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_state_next = LSU_IDLE;
                w_busy_next  = 1'b0;
                w_read_next  = 1'b0;
                w_write_next = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= LSU_IDLE;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_load_data <= '0;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_is_load   <= 1'b0;
            r_off       <= '0;
`ifdef CPU_LSU_ADDR_ERROR_EN
            r_addr_err  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_read      <= w_read_next;
            r_write     <= w_write_next;
            r_done      <= w_done_next;
            r_busy      <= w_busy_next;
            r_addr      <= w_addr_next;
            r_be        <= w_be_next;
            r_wdata     <= w_wdata_next;
            r_load_data <= w_load_next;
            r_size      <= w_size_next;
            r_unsigned  <= w_unsigned_next;
            r_is_load   <= w_is_load_next;
            r_off       <= w_off_next;
`ifdef CPU_LSU_ADDR_ERROR_EN
            r_addr_err  <= w_addr_err_next;
`endif
        end
    end

    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign load_data_o      = r_load_data;
    assign avm_address_o    = r_addr;
    assign avm_read_o       = r_read;
    assign avm_write_o      = r_write;
    assign avm_writedata_o  = r_wdata;
    assign avm_byteenable_o = r_be;
`ifdef CPU_LSU_ADDR_ERROR_EN
    assign addr_error_o     = r_addr_err;
`endif

endmodule

// File: tb/tb_cpu_lsu.sv
// Self-checking bench for cpu_lsu: directed vector table, randomized
// transactions against an arithmetic reference model, and hand-written
// sequences for reset mid-access and ignored requests.
module tb_cpu_lsu;
    import cpu_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    opcode_t     opcode_i;
    logic [31:0] address_i;
    logic [31:0] store_data_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] load_data_o;
    logic [31:0] avm_address_o;
    logic        avm_read_o;
    logic        avm_write_o;
    logic [31:0] avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_waitrequest_i;
    logic [31:0] avm_readdata_i;
`ifdef CPU_LSU_ADDR_ERROR_EN
    logic        addr_error_o;
`endif

    always #5 clk = ~clk;

    cpu_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .start_i           (start_i),
        .opcode_i          (opcode_i),
        .address_i         (address_i),
        .store_data_i      (store_data_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
`ifdef CPU_LSU_ADDR_ERROR_EN
        .addr_error_o      (addr_error_o),
`endif
        .load_data_o       (load_data_o),
        .avm_address_o     (avm_address_o),
        .avm_read_o        (avm_read_o),
        .avm_write_o       (avm_write_o),
        .avm_writedata_o   (avm_writedata_o),
        .avm_byteenable_o  (avm_byteenable_o),
        .avm_waitrequest_i (avm_waitrequest_i),
        .avm_readdata_i    (avm_readdata_i)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_last_load;

    typedef struct {
        opcode_t     op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rd;
        int          waits;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        bit          pulse;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int op_bytes(input opcode_t op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit op_load(input opcode_t op);
        return (op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW);
    endfunction

    function automatic bit op_signed(input opcode_t op);
        return (op == OP_LB || op == OP_LH);
    endfunction

    function automatic logic [31:0] val_mask(input int n);
        if (n == 4) return 32'hFFFF_FFFF;
        return (32'h1 << (8 * n)) - 32'h1;
    endfunction

    // Offset rounded down to the access size (misaligned low bits ignored).
    function automatic int eff_off(input opcode_t op, input logic [31:0] addr);
        int n = op_bytes(op);
        return (int'(addr % 4) / n) * n;
    endfunction

    function automatic logic [3:0] m_be(input opcode_t op, input logic [31:0] addr);
        int n = op_bytes(op);
        logic [7:0] ones = 8'((1 << n) - 1);
        logic [7:0] sh = ones << eff_off(op, addr);
        return sh[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input opcode_t op, input logic [31:0] sd);
        int n = op_bytes(op);
        logic [31:0] v = '0;
        for (int k = 0; k < 4 / n; k++) v = v | ((sd & val_mask(n)) << (8 * n * k));
        return v;
    endfunction

    function automatic logic [31:0] m_load(input opcode_t op, input logic [31:0] addr, input logic [31:0] rd);
        int n = op_bytes(op);
        logic [31:0] v = (rd >> (8 * eff_off(op, addr))) & val_mask(n);
        if (op_signed(op) && v[8 * n - 1]) v = v | ~val_mask(n);
        return v;
    endfunction

    function automatic bit m_misaligned(input opcode_t op, input logic [31:0] addr);
        return (addr % 32'(op_bytes(op))) != 0;
    endfunction

    // ---------------- one transaction with bus slave and checks ----------------
    task automatic run_txn(input opcode_t op, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rd, input int waits, input logic [3:0] ebe,
                           input logic [31:0] ewd, input logic [31:0] eld, input bit pulse);
        bit          is_ld = op_load(op);
        bit          err = 1'b0;
        int          req = 0;
        int          done_cyc = 0;
        bit          kind_ok = 1'b1, addr_ok = 1'b1, be_ok = 1'b1, wd_ok = 1'b1, busy_ok = 1'b1;
        logic [31:0] ld_act = '0;
        logic        err_act = 1'b0;
        logic [31:0] exp_ld;
`ifdef CPU_LSU_ADDR_ERROR_EN
        err = m_misaligned(op, addr);
`endif
        opcode_i     = op;
        address_i    = addr;
        store_data_i = sd;
        start_i      = 1'b1;
        tick();
        start_i = pulse;
        if (pulse) begin
            opcode_i  = OP_SW;
            address_i = $urandom;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (avm_read_o || avm_write_o) begin
                req++;
                if (avm_read_o !== is_ld || avm_write_o !== !is_ld) kind_ok = 1'b0;
                if (avm_address_o !== (addr & 32'hFFFF_FFFC)) addr_ok = 1'b0;
                if (avm_byteenable_o !== ebe) be_ok = 1'b0;
                if (!is_ld && avm_writedata_o !== ewd) wd_ok = 1'b0;
                avm_waitrequest_i = (req <= waits);
                avm_readdata_i    = avm_waitrequest_i ? $urandom : rd;
            end else begin
                avm_waitrequest_i = 1'($urandom_range(0, 1));
                avm_readdata_i    = $urandom;
            end
            if (done_o) begin
                done_cyc = cyc;
                ld_act   = load_data_o;
`ifdef CPU_LSU_ADDR_ERROR_EN
                err_act  = addr_error_o;
`endif
                break;
            end
            tick();
        end
        exp_ld = (is_ld && !err) ? eld : m_last_load;
        chk($sformatf("%s done_latency", op.name()), 32'(done_cyc), err ? 32'd1 : 32'(waits + 2));
        chk($sformatf("%s req_cycles", op.name()), 32'(req), err ? 32'd0 : 32'(waits + 1));
        chk($sformatf("%s req_kind", op.name()), 32'(kind_ok), 32'd1);
        chk($sformatf("%s address", op.name()), 32'(addr_ok), 32'd1);
        chk($sformatf("%s byteenable", op.name()), 32'(be_ok), 32'd1);
        chk($sformatf("%s writedata", op.name()), 32'(wd_ok), 32'd1);
        chk($sformatf("%s busy", op.name()), 32'(busy_ok), 32'd1);
        chk($sformatf("%s load_data", op.name()), ld_act, exp_ld);
`ifdef CPU_LSU_ADDR_ERROR_EN
        chk($sformatf("%s addr_error", op.name()), 32'(err_act), 32'(err));
`else
        chk($sformatf("%s addr_error", op.name()), 32'(err_act), 32'd0);
`endif
        if (is_ld && !err) m_last_load = eld;
        // Cycle after DONE: back to IDLE even if start was high during DONE.
        tick();
        start_i = 1'b0;
        chk($sformatf("%s post_idle", op.name()),
            {28'b0, busy_o, done_o, avm_read_o, avm_write_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        opcode_t ops[8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

        reset_i           = 1'b1;
        start_i           = 1'b0;
        opcode_i          = OP_NOP;
        address_i         = '0;
        store_data_i      = '0;
        avm_waitrequest_i = 1'b0;
        avm_readdata_i    = '0;
        m_last_load       = '0;

        // op, addr, store data, read data, waits, be, writedata, load, pulse
        vecs.push_back('{OP_SW,  32'h0000_1004, 32'hDEAD_BEEF, 32'h0,          0, 4'b1111, 32'hDEAD_BEEF, 32'h0,          1'b0});
        vecs.push_back('{OP_SB,  32'h0000_2003, 32'h0000_00A5, 32'h0,          0, 4'b1000, 32'hA5A5_A5A5, 32'h0,          1'b0});
        vecs.push_back('{OP_LB,  32'h0000_3001, 32'h0,         32'h0000_8000,  0, 4'b0010, 32'h0,         32'hFFFF_FF80,  1'b0});
        vecs.push_back('{OP_LBU, 32'h0000_3001, 32'h0,         32'h0000_8000,  0, 4'b0010, 32'h0,         32'h0000_0080,  1'b0});
        vecs.push_back('{OP_LH,  32'h0000_3002, 32'h0,         32'h8001_FFFF,  0, 4'b1100, 32'h0,         32'hFFFF_8001,  1'b0});
        vecs.push_back('{OP_SH,  32'h4000_0002, 32'hCAFE_1234, 32'h0,          1, 4'b1100, 32'h1234_1234, 32'h0,          1'b0});
        vecs.push_back('{OP_LHU, 32'h0000_3002, 32'h0,         32'h8001_FFFF,  0, 4'b1100, 32'h0,         32'h0000_8001,  1'b0});
        vecs.push_back('{OP_LW,  32'h0000_5000, 32'h0,         32'h1234_5678,  3, 4'b1111, 32'h0,         32'h1234_5678,  1'b1});
        vecs.push_back('{OP_LB,  32'h0000_6000, 32'h0,         32'h7F00_00FF,  1, 4'b0001, 32'h0,         32'hFFFF_FFFF,  1'b0});
        vecs.push_back('{OP_SB,  32'h0000_6001, 32'h1111_113C, 32'h0,          2, 4'b0010, 32'h3C3C_3C3C, 32'h0,          1'b1});
        vecs.push_back('{OP_LBU, 32'h0000_6002, 32'h0,         32'h7FAA_00FF,  0, 4'b0100, 32'h0,         32'h0000_00AA,  1'b0});

        // Reset state.
        tick();
        chk("reset_ctrl", {28'b0, busy_o, done_o, avm_read_o, avm_write_o}, 32'd0);
        chk("reset_addr", avm_address_o, 32'd0);
        chk("reset_wdata", avm_writedata_o, 32'd0);
        chk("reset_be", 32'(avm_byteenable_o), 32'd0);
        chk("reset_load", load_data_o, 32'd0);
        reset_i = 1'b0;
        tick();

        // Directed vectors.
        foreach (vecs[i])
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].sd, vecs[i].rd, vecs[i].waits,
                    vecs[i].be, vecs[i].wd, vecs[i].ld, vecs[i].pulse);

        // Non-memory opcode is ignored.
        opcode_i = OP_ADD;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        begin
            bit quiet = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (busy_o || done_o || avm_read_o || avm_write_o) quiet = 1'b0;
                tick();
            end
            chk("nonmem_ignored", 32'(quiet), 32'd1);
        end

`ifdef CPU_LSU_ADDR_ERROR_EN
        // Misaligned word: immediate DONE with addr_error, no bus cycle.
        run_txn(OP_LW, 32'h0000_1002, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'h0, 1'b0);
`endif

        // Randomized transactions against the model.
        for (int i = 0; i < 60; i++) begin
            opcode_t     op = ops[$urandom_range(0, 7)];
            logic [31:0] a  = $urandom;
            logic [31:0] sd = $urandom;
            logic [31:0] rd = $urandom;
            int          w  = $urandom_range(0, 3);
            run_txn(op, a, sd, rd, w, m_be(op, a), m_wdata(op, sd), m_load(op, a, rd),
                    1'($urandom_range(0, 1)));
        end

        // Reset during ACCESS abandons the transaction.
        avm_waitrequest_i = 1'b1;
        opcode_i          = OP_LW;
        address_i         = 32'h0000_7000;
        start_i           = 1'b1;
        tick();
        start_i = 1'b0;
        chk("rst_mid_read_before", 32'(avm_read_o), 32'd1);
        tick();
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst_mid_ctrl", {28'b0, busy_o, done_o, avm_read_o, avm_write_o}, 32'd0);
        chk("rst_mid_addr", avm_address_o, 32'd0);
        chk("rst_mid_load", load_data_o, 32'd0);
        m_last_load = '0;
        tick();
        reset_i           = 1'b0;
        avm_waitrequest_i = 1'b0;
        begin
            bit quiet = 1'b1;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (done_o || avm_read_o || avm_write_o || busy_o) quiet = 1'b0;
            end
            chk("rst_mid_no_done", 32'(quiet), 32'd1);
        end

        // A load after reset still works.
        run_txn(OP_LH, 32'h0000_8000, 32'h0, 32'h0000_C3A5, 0, 4'b0011, 32'h0, 32'hFFFF_C3A5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_lsu.md
Name: cpu_lsu

Overview:
- Load/store unit: the bus-side counterpart of the execute stage.
- Consumes the effective address, store data and opcode produced by the ALU.
- Runs one Avalon-style memory transaction, honouring waitrequest, and returns an aligned, sign- or zero-extended load value for register write-back.
- Owns byte-lane steering, byteenable generation and the read/write handshake, so the ALU only deals in 32-bit register values.

Parameters:
- ADDR_W, 32, width of the effective address and the bus address.
- DATA_W, 32, bus data width; fixed at 32, with 4 byte lanes.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request strobe; sampled only in IDLE.
- opcode_i  in  opcode_t  one of OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW.
- address_i  in  ADDR_W  effective address (base plus sign-extended offset).
- store_data_i  in  32  rt value; the store datum is in the low bits.
- busy_o  out  1  high while not in IDLE.
- done_o  out  1  one-cycle completion pulse.
- load_data_o  out  32  extended load result; valid while done_o is high and held until the next load completes.
- avm_address_o  out  ADDR_W  word-aligned address ({address[31:2], 2'b00}).
- avm_read_o  out  1  read request.
- avm_write_o  out  1  write request.
- avm_writedata_o  out  32  lane-steered store data.
- avm_byteenable_o  out  4  active lanes.
- avm_waitrequest_i  in  1  slave stall.
- avm_readdata_i  in  32  read data; valid in the cycle where read=1 and waitrequest=0.

Behaviour:
- Byte order: little-endian lanes. Byte at offset k = address[1:0] occupies bits [8k+7:8k] and uses byteenable[k].
- Reset (asynchronous, any state): state=IDLE; read, write, done and busy = 0; load_data_o=0; address, writedata and byteenable = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On start_i with a load/store opcode: latch opcode, address and store data; compute byteenable and writedata; move to ACCESS.
  - start_i with any other opcode is ignored: no bus cycle, no done_o.
- ACCESS:
  - avm_read_o (loads) or avm_write_o (stores) is held high; address, byteenable and writedata are stable.
  - While waitrequest=1: remain in ACCESS with all bus outputs unchanged.
  - On an edge with waitrequest=0: drop read/write, capture readdata (loads only), move to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. start_i seen in DONE is ignored.
- Latency with zero wait states: start at cycle N, bus request in cycle N+1, done_o in cycle N+2. Each wait-state cycle adds 1.
- Byteenable by offset:
  - Byte: 0001, 0010, 0100, 1000 for offsets 0 to 3.
  - Half: 0011 for offset 0, 1100 for offset 2.
  - Word: 1111.
- Store steering:
  - SB: store_data[7:0] is replicated to every lane.
  - SH: store_data[15:0] is replicated to both halves.
  - SW: passed unchanged.
- Load extraction: select the lane(s) by offset, then:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Misaligned half/word access (default build): address[0] is ignored for halves; address[1:0] is ignored for words.
- load_data_o is not updated by stores.
- A reset asserted mid-ACCESS abandons the transaction; no done_o is produced.

Optional Feature:
- Macro: CPU_LSU_ADDR_ERROR_EN.
- When defined:
  - Adds output addr_error_o (1 bit).
  - A misaligned LH, LHU or SH (address[0]=1), or a misaligned LW or SW (address[1:0]≠0), goes IDLE→DONE with no bus cycle.
  - In that DONE cycle, done_o=1 and addr_error_o=1; load_data_o is unchanged.
  - addr_error_o resets to 0 and is otherwise 0.
- When undefined: no port, and the misaligned-address handling described above applies.

Decomposition:
- Package codes:
  - Add OP_LBU and OP_LHU to opcode_t if absent.
  - Add lsu_state_t enum {LSU_IDLE, LSU_ACCESS, LSU_DONE}.
  - Add the access-size enum {SZ_BYTE, SZ_HALF, SZ_WORD}.
- Sub-module cpu_lsu_lane (purely combinational):
  - Inputs: size, unsigned flag, offset, store data, readdata.
  - Outputs: byteenable, writedata, extended load data.
  - cpu_lsu instantiates it and keeps the FSM and registers.

Test Plan:
- SW addr 0x1004, data 0xDEADBEEF, waitrequest=0 → write high for exactly 1 cycle; avm_address=0x1004, byteenable=1111, writedata=0xDEADBEEF; done_o 2 cycles after start.
- SB addr 0x2003, data 0x000000A5 → byteenable=1000, writedata=0xA5A5A5A5.
- LB addr 0x3001, readdata 0x00008000 → load_data_o=0xFFFFFF80. LBU at the same address → 0x00000080.
- LH addr 0x3002, readdata 0x8001FFFF → load_data_o=0xFFFF8001. LHU → 0x00008001.
- LW with waitrequest high for 3 cycles, then readdata 0x12345678 → read held 4 cycles with a stable address; done_o at cycle N+5; result 0x12345678; start_i pulses during busy are ignored.
- Reset asserted mid-ACCESS → read/write drop asynchronously, no done_o. With CPU_LSU_ADDR_ERROR_EN: LW addr 0x1002 → no bus cycle, done_o and addr_error_o high in cycle N+1.
